bcd_uart_ascii_tx: RTL
======================

// Module: bcd_uart_ascii_tx
// PURPOSE
//  Downstream consumer of the hex-to-BCD converter: takes a packed BCD value and
//  transmits it as ASCII decimal text over a UART line (8N1, LSB first), with
//  optional leading-zero suppression and a CR LF terminator.
//  Lets the board report counter values to a host terminal instead of LEDs only.
// PARAMETERS
//  BCD_DIGITS              3    number of BCD nybbles in bcd_in (MS nybble first on the line)
//  CLOCKS_PER_BIT          104  clock cycles per UART bit, >=2 (12 MHz / 115200)
//  SUPPRESS_LEADING_ZEROS  1    1: skip leading '0' digits; the LS digit is always sent
//  APPEND_CRLF             1    1: send 0x0D then 0x0A after the digits
// PORTS
//  clock   in   1              single system clock, all logic on rising edge
//  reset   in   1              synchronous, active-high
//  bcd_in  in   4*BCD_DIGITS   packed BCD, nybble [3:0] = least significant digit
//  start   in   1              request to send; accepted only when busy==0
//  busy    out  1              high from the cycle after acceptance until message complete
//  done    out  1              one-cycle pulse when the last stop bit has completed
//  tx      out  1              UART serial output, idle high
// BEHAVIOUR
//  - Reset: tx=1, busy=0, done=0, FSM->IDLE, bit/baud/char counters=0. Reset mid-frame
//    aborts immediately; tx is 1 on the cycle after reset is sampled.
//  - Accept: start=1 && busy==0 at edge N -> bcd_in latched internally; busy=1 and
//    tx=0 (start bit) from edge N. bcd_in changes after acceptance have no effect.
//  - start while busy==1 is ignored (no queueing).
//  - FSM: IDLE -> START_BIT -> DATA(8 bits) -> STOP_BIT -> NEXT_CHAR decision ->
//    START_BIT (more chars) or IDLE. Every bit held exactly CLOCKS_PER_BIT cycles;
//    frame = 10*CLOCKS_PER_BIT cycles; consecutive chars back-to-back (no idle gap).
//  - Digit encoding: nybble 0..9 -> 0x30+nybble; nybble 10..15 -> '?' (0x3F).
//  - Leading-zero rule (SUPPRESS_LEADING_ZEROS=1): digits are skipped from the MS end
//    while they equal 0 and are not the LS digit; first nonzero (or invalid) digit
//    ends suppression; zeros after it are sent. Skipping consumes no cycles.
//  - Message = selected digits, then CR LF if APPEND_CRLF. Minimum 1 char.
//  - Completion: on the cycle the final stop bit ends, done=1 for exactly one cycle
//    and busy=0 in that same cycle; tx stays 1. A start asserted in the done cycle
//    is accepted (busy already 0) and the next start bit follows with no idle bit.
//  - Widths: baud counter sized for CLOCKS_PER_BIT-1; char index sized for
//    BCD_DIGITS+2; no arithmetic overflow on any legal parameter set.
// TESTING (CLOCKS_PER_BIT=4, BCD_DIGITS=3, defaults otherwise)
//  bcd_in=12'h255, start 1 cycle -> tx bytes 0x32,0x35,0x35,0x0D,0x0A; busy high 200 cycles; done 1 pulse
//  bcd_in=12'h007 -> bytes 0x37,0x0D,0x0A (120 cycles); with SUPPRESS_LEADING_ZEROS=0 -> 0x30,0x30,0x37,0x0D,0x0A
//  bcd_in=12'h000 -> bytes 0x30,0x0D,0x0A; bcd_in=12'h1A3 -> 0x31,0x3F,0x33,0x0D,0x0A
//  start pulsed again 50 cycles into 12'h255 message, bcd_in changed to 12'h999 -> ignored, original 5 bytes unchanged
//  reset asserted mid-data-bit of 2nd char -> tx=1, busy=0, done=0 next cycle; fresh start then sends full message
//  start held high continuously with bcd_in=12'h042 -> "42\r\n" repeated with no idle gap; done pulses every 160 cycles

Source files
------------

// File: rtl/bcd_uart_ascii_tx.sv
`default_nettype none
// ============================================================================
// Module      : bcd_uart_ascii_tx
// Description : Sends a packed BCD value as ASCII decimal text over an 8N1
//               UART line, with optional leading-zero suppression and CR LF.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_uart_ascii_tx #(
    parameter int BCD_DIGITS             = 3,
    parameter int CLOCKS_PER_BIT         = 104,
    parameter bit SUPPRESS_LEADING_ZEROS = 1'b1,
    parameter bit APPEND_CRLF            = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*BCD_DIGITS-1:0] bcd_in,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    tx
);

    localparam int c_BAUD_W   = $clog2(CLOCKS_PER_BIT);
    localparam int c_IDX_W    = $clog2(BCD_DIGITS + 2);
    localparam int c_LAST_IDX = APPEND_CRLF ? BCD_DIGITS + 1 : BCD_DIGITS - 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_DONE = c_BAUD_W'(CLOCKS_PER_BIT - 2);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(c_LAST_IDX);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [1:0]              r_state,  w_state_nxt;
    logic [c_BAUD_W-1:0]     r_baud,   w_baud_nxt;
    logic [2:0]              r_bit,    w_bit_nxt;
    logic [c_IDX_W-1:0]      r_idx,    w_idx_nxt;
    logic [7:0]              r_shift,  w_shift_nxt;
    logic [4*BCD_DIGITS-1:0] r_digits, w_digits_nxt;
    logic                    r_tx,     w_tx_nxt;
    logic                    r_busy,   w_busy_nxt;
    logic                    r_done,   w_done_nxt;

    logic [c_IDX_W-1:0]      w_first_idx;
    logic [c_IDX_W-1:0]      w_idx_inc;
    logic                    w_lead;

    // Character slots: 0..BCD_DIGITS-1 are digits MS first, then CR, then LF.
    function automatic logic [7:0] char_at(input logic [4*BCD_DIGITS-1:0] digits,
                                           input logic [c_IDX_W-1:0]      idx);
        logic [7:0] ch;
        logic [3:0] nyb;
        ch  = 8'h0A;
        nyb = 4'h0;
        if (int'(idx) == BCD_DIGITS) begin
            ch = 8'h0D;
        end else if (int'(idx) < BCD_DIGITS) begin
            for (int d = 0; d < BCD_DIGITS; d++) begin
                if (int'(idx) == BCD_DIGITS - 1 - d) nyb = digits[4*d +: 4];
            end
            ch = (nyb > 4'd9) ? 8'h3F : {4'h3, nyb};
        end
        return ch;
    endfunction

    // Skipped leading zeros are resolved to a starting slot at acceptance.
    always_comb begin
        w_first_idx = '0;
        w_lead      = SUPPRESS_LEADING_ZEROS;
        for (int d = BCD_DIGITS - 1; d >= 1; d--) begin
            if (w_lead && (bcd_in[4*d +: 4] == 4'h0)) begin
                w_first_idx = w_first_idx + 1'b1;
            end else begin
                w_lead = 1'b0;
            end
        end
    end

    assign w_idx_inc = r_idx + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bit_nxt    = r_bit;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_digits_nxt = r_digits;
        w_tx_nxt     = r_tx;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_state_nxt  = c_ST_START;
                    w_digits_nxt = bcd_in;
                    w_idx_nxt    = w_first_idx;
                    w_shift_nxt  = char_at(bcd_in, w_first_idx);
                    w_baud_nxt   = '0;
                    w_tx_nxt     = 1'b0;
                    w_busy_nxt   = 1'b1;
                end
            end
            c_ST_START: begin
                if (r_baud == c_BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = c_ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            c_ST_DATA: begin
                if (r_baud == c_BAUD_LAST) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = c_ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            c_ST_STOP: begin
                // The final stop bit's last cycle is the idle/done cycle, so a
                // start accepted there keeps messages back-to-back.
                if (r_idx == c_IDX_LAST) begin
                    if (r_baud == c_BAUD_DONE) begin
                        w_state_nxt = c_ST_IDLE;
                        w_baud_nxt  = '0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_baud_nxt = r_baud + 1'b1;
                    end
                end else if (r_baud == c_BAUD_LAST) begin
                    w_state_nxt = c_ST_START;
                    w_baud_nxt  = '0;
                    w_idx_nxt   = w_idx_inc;
                    w_shift_nxt = char_at(r_digits, w_idx_inc);
                    w_tx_nxt    = 1'b0;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_digits <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_digits <= w_digits_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire
